// File: rtl/csr_pkg.sv
// Shared CSR/trap definitions: trap sequencer states, interrupt cause base,
// and the mie bit position of external interrupt line 0.
// Purely declarative; no logic, no latency, no flow control.
package csr_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_ENTER,
    IRQ_SERVICE,
    IRQ_EXIT
  } irq_state_t;

  localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;
  localparam int          IRQ_MIE_LSB    = 16;

endpackage

// File: rtl/irq_priority_encoder.sv
// Lowest-index-wins priority encoder over the eligible interrupt vector.
// Latency: purely combinational (0 cycles).
// Backpressure: none; output follows input every cycle.
// Ports: vec_i (N request bits) -> valid_o (any set), idx_o (lowest set index).
module irq_priority_encoder #(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    valid_o = |vec_i;
    idx_o   = '0;
    // Walk from the top down so the lowest set bit is the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Trap sequencer feeding csr_controller: captures interrupt edges, arbitrates
// against core exceptions and runs one handler at a time (entry to mret).
// Latency: irq edge at cycle N -> trap_o at N+2; mret_i -> irq_ret_o next cycle.
// Ports: clk_i/rst_ni; irq_req_i, mie_i, exception_i, exc_cause_i, mret_i in;
//        trap_o, mcause_o, irq_ret_o, irq_ack_o, busy_o out.
module irq_controller
  import csr_pkg::*;
#(
  parameter int NUM_IRQ = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_IRQ-1:0] irq_req_i,
  input  logic [31:0]        mie_i,
  input  logic               exception_i,
  input  logic [31:0]        exc_cause_i,
  input  logic               mret_i,
  output logic               trap_o,
  output logic [31:0]        mcause_o,
  output logic               irq_ret_o,
  output logic [NUM_IRQ-1:0] irq_ack_o,
  output logic               busy_o
);

  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  irq_state_t         state_q, state_d;
  logic [NUM_IRQ-1:0] req_d_q, pend_q;
  logic [NUM_IRQ-1:0] pend_set, pend_clr, eligible;
  logic [31:0]        mcause_q, mcause_d;
  logic [IW-1:0]      src_q, src_d, win_idx;
  logic               src_irq_q, src_irq_d;
  logic               win_vld;
  logic               unused_mie;

  // Only the interrupt-enable field of mie matters here.
  assign unused_mie = ^mie_i;

  assign pend_set = irq_req_i & ~req_d_q;
  assign eligible = pend_q & mie_i[IRQ_MIE_LSB +: NUM_IRQ];

  irq_priority_encoder #(.N(NUM_IRQ), .IW(IW)) u_prio (
    .vec_i   (eligible),
    .valid_o (win_vld),
    .idx_o   (win_idx)
  );

  always_comb begin
    state_d   = state_q;
    mcause_d  = mcause_q;
    src_d     = src_q;
    src_irq_d = src_irq_q;
    pend_clr  = '0;
    case (state_q)
      IRQ_IDLE: begin
        if (exception_i) begin
          mcause_d  = exc_cause_i;
          src_irq_d = 1'b0;
          state_d   = IRQ_ENTER;
        end else if (win_vld) begin
          mcause_d  = IRQ_CAUSE_BASE + 32'(win_idx);
          src_d     = win_idx;
          src_irq_d = 1'b1;
          // Cleared on entry, so a fresh edge during the handler re-pends.
          pend_clr  = NUM_IRQ'(1) << win_idx;
          state_d   = IRQ_ENTER;
        end
      end
      IRQ_ENTER: state_d = IRQ_SERVICE;
      IRQ_SERVICE: begin
        // An exception inside a handler abandons any interrupt being served.
        if (exception_i) begin
          mcause_d  = exc_cause_i;
          src_irq_d = 1'b0;
          state_d   = IRQ_ENTER;
        end else if (mret_i) begin
          state_d = IRQ_EXIT;
        end
      end
      IRQ_EXIT: state_d = IRQ_IDLE;
      default:  state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IRQ_IDLE;
      req_d_q   <= '0;
      pend_q    <= '0;
      mcause_q  <= '0;
      src_q     <= '0;
      src_irq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_d_q   <= irq_req_i;
      // Set after clear: a new edge in the clearing cycle is kept.
      pend_q    <= (pend_q & ~pend_clr) | pend_set;
      mcause_q  <= mcause_d;
      src_q     <= src_d;
      src_irq_q <= src_irq_d;
    end
  end

  assign mcause_o  = mcause_q;
  assign trap_o    = (state_q == IRQ_ENTER);
  assign irq_ret_o = (state_q == IRQ_EXIT);
  assign busy_o    = (state_q == IRQ_ENTER) || (state_q == IRQ_SERVICE);
  assign irq_ack_o = ((state_q == IRQ_EXIT) && src_irq_q) ? (NUM_IRQ'(1) << src_q)
                                                          : '0;

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Trap sequencer that sits in front of csr_controller. It drives that block's trap_i and mcause_i inputs from two sources: core exceptions and external interrupt lines.
- External interrupt lines are captured on their rising edge, masked by mie, and prioritised.
- The block sequences trap entry and mret return, so only one trap handler runs at a time.
- It tells each interrupt source when its request has been serviced.

Parameters:
- NUM_IRQ, 16, number of external interrupt lines (legal range 1..16). Line k maps to mie bit 16+k and to mcause 32'h8000_0010+k.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- irq_req_i  in  NUM_IRQ  interrupt request levels; synchronous to clk_i; a rising edge makes the line pending.
- mie_i  in  32  from csr_controller mie_o; bits [16+NUM_IRQ-1:16] enable lines 0..NUM_IRQ-1.
- exception_i  in  1  core reports a synchronous exception this cycle.
- exc_cause_i  in  32  exception cause code, valid while exception_i=1.
- mret_i  in  1  core is executing mret this cycle.
- trap_o  in/out: out  1  one-cycle pulse to csr_controller trap_i; mepc and mcause are captured on this cycle.
- mcause_o  out  32  cause for the current trap; held stable from the ENTER state until the next trap.
- irq_ret_o  out  1  one-cycle pulse: return from the handler is complete; the core loads mepc.
- irq_ack_o  out  NUM_IRQ  one-hot one-cycle pulse naming the interrupt line whose handler returned.
- busy_o  out  1  a handler is active (state ENTER or SERVICE).

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=IDLE.
  - Pending register and edge-detect register are 0.
  - mcause_o=0; trap_o, irq_ret_o, irq_ack_o and busy_o are all 0.
- Edge capture:
  - req_d_q <= irq_req_i every cycle.
  - pend_set = irq_req_i & ~req_d_q.
  - pend_q <= (pend_q & ~pend_clr) | pend_set.
  - If a line is set and cleared in the same cycle, set wins (the new request is not lost).
- Eligibility:
  - eligible = pend_q & mie_i[16 +: NUM_IRQ].
  - A masked line stays pending and fires once its mie bit is set.
- Priority: the lowest index wins; computed combinationally.
- States:
  - IDLE:
    - If exception_i: mcause_q <= exc_cause_i, src_irq_q <= 0 (exception flag), go to ENTER.
    - Else if eligible != 0: mcause_q <= 32'h8000_0010 + idx, src_q <= idx, src_irq_q <= 1, go to ENTER.
    - An exception beats an interrupt in the same cycle; the interrupt stays pending.
    - mret_i in IDLE is ignored: no irq_ret_o pulse.
  - ENTER:
    - trap_o=1 for exactly this cycle; then go to SERVICE.
    - exception_i and mret_i are ignored in this state (the core is flushing).
    - Latency: request edge at cycle N sets pend_q at N+1, the winner is latched at N+1, and trap_o is high at cycle N+2.
  - SERVICE:
    - No interrupt nesting; interrupts stay pending.
    - exception_i in SERVICE: mcause_q <= exc_cause_i, src_irq_q <= 0, go to ENTER. The original interrupt is then abandoned: no ack, and its pend bit is already 0.
    - mret_i (without an exception in the same cycle): go to EXIT.
    - If exception_i and mret_i arrive together, exception wins.
  - EXIT:
    - irq_ret_o=1 for one cycle.
    - If src_irq_q: irq_ack_o[src_q]=1.
    - Go to IDLE.
    - A new eligible interrupt may be taken on the next IDLE cycle, so the minimum gap between back-to-back traps is 2 cycles.
- Pending-bit clear: pend_clr is asserted for the winning index in the IDLE→ENTER cycle, not at EXIT. A fresh edge on that line during SERVICE therefore re-pends it.
- mcause_o is driven from mcause_q (registered).
- The block never reads mtvec or mepc; csr_controller owns both.
- Illegal state encoding: recover to IDLE with all pulse outputs 0.

Decomposition:
- csr_pkg gains:
  - typedef enum logic [1:0] irq_state_t {IRQ_IDLE, IRQ_ENTER, IRQ_SERVICE, IRQ_EXIT};
  - localparam IRQ_CAUSE_BASE = 32'h8000_0010;
  - localparam IRQ_MIE_LSB = 16.
- One sub-module, irq_priority_encoder (parameter N):
  - inputs: eligible vector.
  - outputs: valid and the index of the lowest set bit; purely combinational.

Test Plan:
- Reset mid-SERVICE: rst_ni low for 1 cycle → state IDLE, busy_o=0, pend_q=0, mcause_o=0. No irq_ret_o or irq_ack_o follows a later mret_i.
- Single interrupt: mie_i=32'h0001_0000, pulse irq_req_i[0] at cycle 10 → trap_o=1 at cycle 12 only, with mcause_o=32'h8000_0010. Then mret_i at cycle 20 → irq_ret_o=1 and irq_ack_o=16'h0001 at cycle 21.
- Priority and masking:
  - Raise lines 3 and 5 together with mie_i=32'h0028_0000 → first trap has mcause 32'h8000_0013.
  - After its mret, the second trap has mcause 32'h8000_0015.
  - With mie bit 19 cleared instead, line 5 is taken first and line 3 stays pending until the mask is set.
- Exception vs interrupt: exception_i=1 with exc_cause_i=32'h2, in the same cycle as an eligible irq 1 → trap with mcause 2. On mret: irq_ret_o=1, irq_ack_o=0, then a second trap with mcause 32'h8000_0011.
- Nested exception in SERVICE of irq 4: exception_i with cause 32'hB → a second trap_o pulse with mcause 32'hB. On mret: irq_ack_o=0. A re-raised irq 4 edge during SERVICE is still taken after return.
- Set/clear collision: a second rising edge on irq 2 in the same cycle the IDLE→ENTER transition clears pend[2] → pend[2] stays 1, and a second trap for line 2 follows after mret.
